// File: rtl/bru_queue.sv
// Branch resolution unit: evaluates issued branch/jump ops against the front-end
// prediction and queues the results in a small FIFO for the commit/redirect logic.
module bru_queue #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_next_pc,
  output logic [XLEN-1:0]  out_link,
  output logic             out_link_we,
  output logic             out_mispredict,
  output logic [CNT_W-1:0] cnt_resolved,
  output logic [CNT_W-1:0] cnt_mispredict
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_EQ   = 4'd1,
    OP_NE   = 4'd2,
    OP_LT   = 4'd3,
    OP_GE   = 4'd4,
    OP_LTU  = 4'd5,
    OP_GEU  = 4'd6,
    OP_JAL  = 4'd7,
    OP_JALR = 4'd8
  } op_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic [XLEN-1:0]  next_pc;
    logic [XLEN-1:0]  link;
    logic             link_we;
    logic             mispredict;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic             op_real, is_link, is_jalr, taken;
  logic [XLEN-1:0]  target, seq_pc;
  logic             push, pop;

  assign in_ready  = (count < FULL_CNT) & ~flush;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & op_real;
  assign pop       = out_valid & out_ready & ~flush;

  // NOTE: every always_comb output gets a default before the case so that
  // unlisted op codes cannot leave a signal unassigned and infer a latch.
  always_comb begin
    op_real = 1'b1;
    is_link = 1'b0;
    is_jalr = 1'b0;
    taken   = 1'b0;
    case (op_e'(in_op))
      OP_EQ:   taken = (in_src1 == in_src2);
      OP_NE:   taken = (in_src1 != in_src2);
      OP_LT:   taken = ($signed(in_src1) <  $signed(in_src2));
      OP_GE:   taken = ($signed(in_src1) >= $signed(in_src2));
      OP_LTU:  taken = (in_src1 <  in_src2);
      OP_GEU:  taken = (in_src1 >= in_src2);
      OP_JAL:  begin taken = 1'b1; is_link = 1'b1; end
      OP_JALR: begin taken = 1'b1; is_link = 1'b1; is_jalr = 1'b1; end
      default: op_real = 1'b0;
    endcase

    seq_pc = in_pc + XLEN'(4);
    target = is_jalr ? ((in_src1 + in_imm) & ~XLEN'(1)) : (in_pc + (in_imm << 1));

    new_entry.tag        = in_tag;
    new_entry.taken      = taken;
    new_entry.next_pc    = taken ? target : seq_pc;
    new_entry.link       = is_link ? seq_pc : '0;
    new_entry.link_we    = is_link;
    new_entry.mispredict = (taken != in_pred_taken) | (taken & (target != in_pred_target));
  end

  // NOTE: the payload array carries no reset; out_valid (from count) qualifies
  // every read, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  // Performance counters survive flush and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_resolved   <= '0;
      cnt_mispredict <= '0;
    end else if (pop) begin
      if (cnt_resolved != '1) cnt_resolved <= cnt_resolved + CNT_W'(1);
      if (head.mispredict && cnt_mispredict != '1)
        cnt_mispredict <= cnt_mispredict + CNT_W'(1);
    end
  end

  always_comb begin
    head           = out_valid ? mem[rd_ptr] : '0;
    out_tag        = head.tag;
    out_taken      = head.taken;
    out_next_pc    = head.next_pc;
    out_link       = head.link;
    out_link_we    = head.link_we;
    out_mispredict = head.mispredict;
  end

endmodule

// File: tb/tb_bru_queue.sv
// Directed bench for bru_queue: a queue-based reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_bru_queue;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk, rst_n, flush;
  logic             in_valid, in_ready;
  logic [3:0]       in_op;
  logic [XLEN-1:0]  in_src1, in_src2, in_pc, in_imm, in_pred_target;
  logic [TAG_W-1:0] in_tag;
  logic             in_pred_taken;
  logic             out_valid, out_ready;
  logic [TAG_W-1:0] out_tag;
  logic             out_taken, out_link_we, out_mispredict;
  logic [XLEN-1:0]  out_next_pc, out_link;
  logic [CNT_W-1:0] cnt_resolved, cnt_mispredict;

  bru_queue #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_pc(in_pc), .in_imm(in_imm),
    .in_tag(in_tag), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_taken(out_taken), .out_next_pc(out_next_pc), .out_link(out_link),
    .out_link_we(out_link_we), .out_mispredict(out_mispredict),
    .cnt_resolved(cnt_resolved), .cnt_mispredict(cnt_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic [XLEN-1:0]  next_pc;
    logic [XLEN-1:0]  link;
    logic             link_we;
    logic             mis;
  } exp_t;

  exp_t             mq[$];
  int               m_res = 0;
  int               m_mis = 0;
  logic [TAG_W-1:0] popped[$];

  function automatic exp_t model_eval(input logic [3:0] op, input logic [XLEN-1:0] s1, s2, pc, imm,
                                      input logic [TAG_W-1:0] tag, input logic pt,
                                      input logic [XLEN-1:0] ptgt);
    exp_t e;
    logic tk;
    logic [XLEN-1:0] tgt;
    case (op)
      4'd1: tk = (s1 == s2);
      4'd2: tk = (s1 != s2);
      4'd3: tk = ($signed(s1) < $signed(s2));
      4'd4: tk = !($signed(s1) < $signed(s2));
      4'd5: tk = (s1 < s2);
      4'd6: tk = !(s1 < s2);
      default: tk = 1'b1;
    endcase
    if (op == 4'd8) tgt = (s1 + imm) & 32'hFFFF_FFFE;
    else            tgt = pc + imm * 2;
    e.tag     = tag;
    e.taken   = tk;
    e.next_pc = tk ? tgt : pc + 4;
    e.link_we = (op == 4'd7) || (op == 4'd8);
    e.link    = e.link_we ? pc + 4 : 32'h0;
    e.mis     = (tk != pt) || (tk && tgt != ptgt);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t h;
    logic exp_ready;
    if (!rst_n) begin
      mq.delete();
      m_res = 0;
      m_mis = 0;
      check("rst out_valid", out_valid, 0);
      check("rst cnt_resolved", cnt_resolved, 0);
      check("rst cnt_mispredict", cnt_mispredict, 0);
    end else begin
      exp_ready = (mq.size() < DEPTH) && !flush;
      h = '{default: 0};
      if (mq.size() != 0) h = mq[0];
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, mq.size() != 0);
      check("out_tag", out_tag, h.tag);
      check("out_taken", out_taken, h.taken);
      check("out_next_pc", out_next_pc, h.next_pc);
      check("out_link", out_link, h.link);
      check("out_link_we", out_link_we, h.link_we);
      check("out_mispredict", out_mispredict, h.mis);
      check("cnt_resolved", cnt_resolved, m_res);
      check("cnt_mispredict", cnt_mispredict, m_mis);
      // Predict the effect of the coming rising edge.
      if (mq.size() != 0 && out_ready && !flush) begin
        popped.push_back(out_tag);
        if (m_res < CNT_MAX) m_res++;
        if (h.mis && m_mis < CNT_MAX) m_mis++;
        void'(mq.pop_front());
      end
      if (flush) mq.delete();
      if (in_valid && exp_ready && in_op >= 4'd1 && in_op <= 4'd8)
        mq.push_back(model_eval(in_op, in_src1, in_src2, in_pc, in_imm, in_tag,
                                in_pred_taken, in_pred_target));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [XLEN-1:0] s1, s2, pc, imm,
                       input logic [TAG_W-1:0] tag, input logic pt, input logic [XLEN-1:0] ptgt);
    in_valid = 1'b1; in_op = op; in_src1 = s1; in_src2 = s2; in_pc = pc; in_imm = imm;
    in_tag = tag; in_pred_taken = pt; in_pred_target = ptgt;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_op    = 4'd0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    bit accepted;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(4'd0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    #3;
    check("por out_valid", out_valid, 0);
    check("por cnt_resolved", cnt_resolved, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    tick();
    check("post-reset in_ready", in_ready, 1);

    // BEQ taken, predicted not taken
    drive(4'd1, 32'd5, 32'd5, 32'h100, 32'h10, 5'd1, 1'b0, 32'h0);
    tick();
    idle();
    at_neg();
    check("beq out_valid", out_valid, 1);
    check("beq taken", out_taken, 1);
    check("beq next_pc", out_next_pc, 32'h120);
    check("beq mispredict", out_mispredict, 1);
    check("beq link_we", out_link_we, 0);
    tick();
    pop_one();
    check("beq cnt_resolved", cnt_resolved, 1);
    check("beq cnt_mispredict", cnt_mispredict, 1);

    // NOP and out-of-range codes leave no entry
    drive(4'd0, 1, 1, 32'h40, 0, 5'd7, 1'b0, 0);
    tick();
    drive(4'd12, 1, 1, 32'h40, 0, 5'd8, 1'b0, 0);
    tick();
    idle();
    at_neg();
    check("nop no entry", out_valid, 0);
    tick();

    // Signed vs unsigned less-than on the same operands
    drive(4'd3, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8, 5'd2, 1'b1, 32'h210);
    tick();
    drive(4'd5, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h8, 5'd3, 1'b1, 32'h310);
    tick();
    idle();
    at_neg();
    check("blt tag", out_tag, 2);
    check("blt taken", out_taken, 1);
    check("blt next_pc", out_next_pc, 32'h210);
    check("blt mispredict", out_mispredict, 0);
    tick();
    pop_one();
    at_neg();
    check("bltu tag", out_tag, 3);
    check("bltu taken", out_taken, 0);
    check("bltu next_pc", out_next_pc, 32'h304);
    check("bltu mispredict", out_mispredict, 1);
    tick();
    pop_one();

    // JALR clears bit 0 of the computed target
    drive(4'd8, 32'h2001, 32'h0, 32'h400, 32'h2, 5'd4, 1'b1, 32'h2002);
    tick();
    idle();
    at_neg();
    check("jalr next_pc", out_next_pc, 32'h2002);
    check("jalr link", out_link, 32'h404);
    check("jalr link_we", out_link_we, 1);
    check("jalr mispredict", out_mispredict, 0);
    tick();
    pop_one();

    // Backpressure: third op refused while full, order kept on drain
    popped.delete();
    drive(4'd7, 0, 0, 32'h600, 32'h10, 5'd10, 1'b0, 32'h0);
    tick();
    drive(4'd7, 0, 0, 32'h610, 32'h10, 5'd11, 1'b1, 32'h630);
    tick();
    drive(4'd7, 0, 0, 32'h620, 32'h10, 5'd12, 1'b1, 32'h640);
    check("full in_ready", in_ready, 0);
    tick();
    out_ready = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      if (in_ready) accepted = 1'b1;
      tick();
    end
    idle();
    for (int i = 0; i < 10 && popped.size() < 3; i++) tick();
    out_ready = 1'b0;
    check("drain count", popped.size(), 3);
    if (popped.size() == 3) begin
      check("drain tag0", popped[0], 10);
      check("drain tag1", popped[1], 11);
      check("drain tag2", popped[2], 12);
    end
    check("drain cnt_resolved", cnt_resolved, 7);
    check("drain cnt_mispredict", cnt_mispredict, 3);

    // Flush a full FIFO while the consumer is ready
    drive(4'd7, 0, 0, 32'h700, 32'h10, 5'd20, 1'b1, 32'h720);
    tick();
    drive(4'd7, 0, 0, 32'h710, 32'h10, 5'd21, 1'b1, 32'h730);
    tick();
    drive(4'd7, 0, 0, 32'h500, 32'h40, 5'd22, 1'b1, 32'h580);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    check("flush in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    check("flush out_valid", out_valid, 0);
    check("flush cnt_resolved", cnt_resolved, 7);
    check("flush cnt_mispredict", cnt_mispredict, 3);
    check("after flush in_ready", in_ready, 1);
    tick();
    idle();
    at_neg();
    check("after flush tag", out_tag, 22);
    tick();
    pop_one();

    // Streaming mispredicts drive both counters into saturation
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      case (i % 4)
        0: drive(4'd2, 32'd1, 32'd2, 32'h800, 32'h4, 5'(i), 1'b0, 32'h0);
        1: drive(4'd4, 32'd5, 32'd3, 32'h810, 32'h4, 5'(i), 1'b0, 32'h0);
        2: drive(4'd7, 32'd0, 32'd0, 32'h820, 32'h4, 5'(i), 1'b1, 32'h999);
        default: drive(4'd6, 32'd1, 32'd2, 32'h830, 32'h4, 5'(i), 1'b1, 32'h838);
      endcase
      tick();
    end
    idle();
    tick();
    tick();
    out_ready = 1'b0;
    check("sat cnt_resolved", cnt_resolved, 4'hF);
    check("sat cnt_mispredict", cnt_mispredict, 4'hF);

    // Asynchronous reset mid-cycle with an entry queued
    drive(4'd7, 0, 0, 32'h900, 32'h10, 5'd30, 1'b1, 32'h920);
    tick();
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst out_tag", out_tag, 0);
    check("async rst cnt_resolved", cnt_resolved, 0);
    check("async rst cnt_mispredict", cnt_mispredict, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    tick();
    check("after rst in_ready", in_ready, 1);
    check("after rst out_valid", out_valid, 0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bru_queue.md
# bru_queue

Parametrised, registered branch resolution unit for the out-of-order backend. Accepts issued branch/jump micro-ops over a valid/ready handshake, evaluates the condition and actual next PC, compares them with the front-end prediction, and buffers results in a DEPTH-entry FIFO drained by the commit/redirect logic. It also keeps saturating resolved-branch and mispredict counters for performance monitoring.

## Interface
- XLEN, 32: data/PC width.
- TAG_W, 5: ROB tag width.
- DEPTH, 2: result FIFO entries (power of two, ≥2).
- CNT_W, 32: performance counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  issue slot holds a branch op.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  4  0 NOP, 1 EQ, 2 NE, 3 LT, 4 GE, 5 LTU, 6 GEU, 7 JAL, 8 JALR; 9–15 treated as NOP.
- in_src1, in_src2  in  XLEN  register operands.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  sign-extended immediate.
- in_tag  in  TAG_W  ROB tag.
- in_pred_taken  in  1  front-end taken prediction.
- in_pred_target  in  XLEN  front-end predicted target.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer accepts head.
- out_tag  out  TAG_W  ROB tag of head.
- out_taken  out  1  actual direction.
- out_next_pc  out  XLEN  actual next PC.
- out_link  out  XLEN  pc+4 (valid for JAL/JALR, else 0).
- out_link_we  out  1  head is JAL/JALR.
- out_mispredict  out  1  head differs from prediction.
- cnt_resolved, cnt_mispredict  out  CNT_W  performance counters.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Conditions: EQ/NE equality; LT/GE signed; LTU/GEU unsigned; JAL/JALR always taken.
- Target: branches and JAL = in_pc + (in_imm << 1), mod 2^XLEN; JALR = (in_src1 + in_imm) & ~1.
- next_pc = taken ? target : in_pc + 4.
- mispredict = (taken != in_pred_taken) | (taken & (target != in_pred_target)).
- NOP (and codes 9–15): accepted when in_ready, consumed, no FIFO entry, counters untouched.
- Non-NOP in_fire pushes {tag, taken, next_pc, link, link_we, mispredict}; computation is combinational into the entry.
- FIFO: read/write pointers log2(DEPTH) bits wrapping modulo DEPTH; count 0..DEPTH.
- in_ready = (count < DEPTH) & ~flush; depends only on registered state and flush, never on out_ready (push into full FIFO refused even if popping same cycle).
- Push and pop in the same cycle: both occur, count unchanged.
- flush: count, pointers cleared next edge; out_valid drops next cycle; in_ready low during flush so nothing accepted; head is not popped into counters even if out_ready.
- Counters: on out_fire (not during flush) cnt_resolved += 1; additionally cnt_mispredict += 1 if head mispredict; both saturate at all-ones. Not cleared by flush.
- Output fields are 0 when out_valid = 0.

## Timing
- Latency: op accepted at edge N is visible at head (if FIFO was empty) from cycle after edge N; out_valid high the cycle after acceptance.
- Throughput: one op/cycle while consumer drains each cycle.
- Reset (rst_n low, asynchronous): count, pointers, counters = 0; out_valid = 0, all out_* = 0; in_ready = 1 after deassert (0 while rst_n low is allowed). Reset mid-traffic discards all entries.
- Head output held stable while out_valid & ~out_ready.

## Test plan
- BEQ src1=src2=5, pc=0x100, imm=0x10, pred_taken=0 -> next cycle out_taken=1, out_next_pc=0x120, out_mispredict=1; after drain cnt_resolved=1, cnt_mispredict=1.
- BLT src1=0xFFFFFFFF, src2=1 vs BLTU same operands, both pred_taken=1 target correct -> BLT taken no mispredict; BLTU not taken, next_pc=pc+4, mispredict=1.
- JALR src1=0x2001, imm=2, pc=0x400 -> next_pc=0x2002, out_link=0x404, out_link_we=1.
- out_ready=0, issue 3 valid ops back-to-back with DEPTH=2 -> first two accepted, in_ready=0 third cycle; raise out_ready with in_valid high -> order preserved by tag, no loss or duplicate.
- FIFO full, assert flush with out_ready=1 -> next cycle out_valid=0, counters unchanged; new op accepted the cycle after flush.
- Preload counters to all-ones via 2^CNT_W mispredicts (use CNT_W=4) -> further mispredicts leave both at 0xF; async rst_n pulse mid-cycle clears all immediately.
